manual_bp_lookup: RTL and testbench
===================================

MANUAL_BP_LOOKUP -- requirements
Module: manual_bp_lookup

Interface
REQ-001 Parameters: ADDR_WIDTH, 7, table address width; DATA_WIDTH, 32, table entry width; PIX_WIDTH, 14, pixel width; IMG_WIDTH, 640, pixels per line; IMG_HEIGHT, 512, lines per frame.
REQ-002 Ports, clock and reset first:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- bp_en, in, 1, lookup enable.
- bp_num, in, ADDR_WIDTH+1, valid table entries.
- frame_start, in, 1, one-cycle pulse before each frame's first pixel.
- s_valid, in, 1, input pixel valid.
- s_ready, out, 1, input pixel accepted.
- s_data, in, PIX_WIDTH, input pixel.
- m_valid, out, 1, output pixel valid.
- m_ready, in, 1, downstream accepts.
- m_data, out, PIX_WIDTH, output pixel.
- m_bad, out, 1, output pixel is a table bad point.
- tbl_en, out, 1, table read enable.
- tbl_addr, out, ADDR_WIDTH, table read address.
- tbl_dout, in, DATA_WIDTH, table read data; valid one cycle after tbl_en.
REQ-003 Entry format: tbl_dout[31:16] = row, [15:0] = column; raster-sorted ascending; write port not driven by this block.

Function
REQ-004 Internal col/row counters advance on each s_valid&&s_ready; col wraps at IMG_WIDTH-1 and increments row; row wraps at IMG_HEIGHT-1; both clear on frame_start.
REQ-005 States IDLE, LOAD, RUN; frame_start in any state -> LOAD; LOAD -> RUN when prefetch buffer holds 2 entries or all entries requested and returned; RUN -> IDLE after last pixel (row IMG_HEIGHT-1, col IMG_WIDTH-1) accepted.
REQ-006 On LOAD entry: bp_num and bp_en latched, read pointer cleared, prefetch buffer and in-flight flag cleared; bp_num > 2^ADDR_WIDTH clamps to 2^ADDR_WIDTH.
REQ-007 Prefetch buffer: 2 entries (cur, nxt); tbl_en asserted, with tbl_addr = read pointer, when occupancy + in-flight < 2 and read pointer < latched bp_num, in LOAD or RUN; pointer increments per read.
REQ-008 s_ready = (state != LOAD) && (!m_valid || m_ready) && !stale, where stale = cur valid && {row,col} of cur < current pixel {row,col}.
REQ-009 Stale cur entry popped in one cycle without flagging (unsorted/duplicate tolerance).
REQ-010 Output register: on accept, m_data <= s_data, m_valid <= 1, latency 1 cycle; m_valid clears when m_ready && no new accept; m_data/m_bad held while m_valid && !m_ready.
REQ-011 m_bad <= 1 when accepted pixel coordinate equals cur in RUN with latched bp_en=1; cur popped same cycle (nxt shifts, concurrent refill allowed); back-to-back adjacent bad pixels flag without stall.
REQ-012 In IDLE pixels pass with m_bad=0; latched bp_en=0 or bp_num=0 -> m_bad always 0, no table reads.
REQ-013 frame_start mid-frame aborts current frame: pending output beat still completes, new LOAD proceeds.
REQ-014 Table exhaustion: no reads beyond bp_num-1; empty buffer never flags.

Reset
REQ-015 rst_n low asynchronously: state IDLE, counters 0, buffer empty, in-flight 0, m_valid 0, m_data 0, m_bad 0, tbl_en 0, tbl_addr 0, s_ready 0 while asserted.
REQ-016 First frame_start after release behaves as REQ-006.

Configuration
REQ-017 Macro MANUAL_BP_STATS_EN defined: extra output bp_hit_cnt (ADDR_WIDTH+1 bits) counts m_bad assertions per frame, cleared on frame_start, saturating at all-ones; undefined: port and counter absent, all other behaviour identical.

Verification
REQ-018 Reset then frame_start, bp_num=0, full frame -> no tbl_en, m_bad never 1, 327680 output beats.
REQ-019 Table {(0,0),(0,1),(5,639),(511,639)}, bp_num=4, m_ready=1 -> m_bad exactly on those 4 pixels, incl. first and last pixel, no stall at (0,1).
REQ-020 Table {(3,10),(2,5),(3,12)} -> (2,5) skipped unflagged, (3,10),(3,12) flagged, one-cycle s_ready drop at stale pop.
REQ-021 Random m_ready at 50% with REQ-019 table -> output sequence identical to m_ready=1 case, m_data held when stalled.
REQ-022 frame_start at row 100 with bp_en=0 at latch -> new frame no flags; MANUAL_BP_STATS_EN build: bp_hit_cnt=4 after REQ-019 frame.

Source files
------------

// File: rtl/manual_bp_lookup.sv
// manual_bp_lookup: flags table-listed bad pixels in a raster stream; define MANUAL_BP_STATS_EN to add the per-frame hit counter bp_hit_cnt
module manual_bp_lookup #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int PIX_WIDTH  = 14,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bp_en,
  input  logic [ADDR_WIDTH:0]   bp_num,
  input  logic                  frame_start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIX_WIDTH-1:0]  s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PIX_WIDTH-1:0]  m_data,
  output logic                  m_bad,
  output logic                  tbl_en,
  output logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic [DATA_WIDTH-1:0] tbl_dout
`ifdef MANUAL_BP_STATS_EN
  ,
  output logic [ADDR_WIDTH:0]   bp_hit_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  localparam logic [15:0] COL_MAX = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] ROW_MAX = 16'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH:0] NUM_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [15:0]           row_q, row_d, col_q, col_d;
  logic [ADDR_WIDTH:0]   num_q, num_d, ptr_q, ptr_d;
  logic                  infl_q;
  logic                  cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d, nxt_q, nxt_d;
  logic                  m_valid_q, m_bad_q;
  logic [PIX_WIDTH-1:0]  m_data_q;
  logic [31:0]           pix;
  logic                  stale, match, acc, hit, pop, last;
  logic [1:0]            occ;

  assign pix      = {row_q, col_q};
  assign stale    = cur_v_q && (cur_q[31:0] < pix);
  assign match    = (state_q == RUN) && cur_v_q && (cur_q[31:0] == pix);
  assign s_ready  = rst_n && (state_q != LOAD) && (!m_valid_q || m_ready) && !stale;
  assign acc      = s_valid && s_ready;
  assign hit      = acc && match;
  assign pop      = stale || hit;
  assign last     = (row_q == ROW_MAX) && (col_q == COL_MAX);
  // occupancy after this cycle's pop plus the read in flight, so a pop can refill immediately
  assign occ      = {1'b0, cur_v_q} + {1'b0, nxt_v_q} + {1'b0, infl_q} - {1'b0, pop};
  assign tbl_en   = !frame_start && (state_q != IDLE) && (occ < 2'd2) && (ptr_q < num_q);
  assign tbl_addr = ptr_q[ADDR_WIDTH-1:0];
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_bad    = m_bad_q;

  // prefetch buffer: pop shifts nxt into cur, returning read data fills the first free slot
  always_comb begin
    cur_v_d = cur_v_q;
    cur_d   = cur_q;
    nxt_v_d = nxt_v_q;
    nxt_d   = nxt_q;
    if (pop) begin
      cur_v_d = nxt_v_q;
      cur_d   = nxt_q;
      nxt_v_d = 1'b0;
    end
    if (infl_q && !cur_v_d) begin
      cur_v_d = 1'b1;
      cur_d   = tbl_dout;
    end else if (infl_q) begin
      nxt_v_d = 1'b1;
      nxt_d   = tbl_dout;
    end
    if (frame_start) begin
      cur_v_d = 1'b0;
      nxt_v_d = 1'b0;
    end
  end

  // frame sequencing, raster counters and table pointer
  always_comb begin
    state_d = state_q;
    if (state_q == LOAD && ((cur_v_q && nxt_v_q) || (ptr_q == num_q && !infl_q))) state_d = RUN;
    if (state_q == RUN && acc && last) state_d = IDLE;
    if (frame_start) state_d = LOAD;
    col_d = frame_start ? 16'd0 : !acc ? col_q : (col_q == COL_MAX) ? 16'd0 : col_q + 16'd1;
    row_d = frame_start ? 16'd0 : !(acc && col_q == COL_MAX) ? row_q : (row_q == ROW_MAX) ? 16'd0 : row_q + 16'd1;
    num_d = !frame_start ? num_q : !bp_en ? '0 : (bp_num > NUM_MAX) ? NUM_MAX : bp_num;
    ptr_d = frame_start ? '0 : ptr_q + {{ADDR_WIDTH{1'b0}}, tbl_en};
  end

  // state registers; output register holds its beat until taken downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      num_q     <= '0;
      ptr_q     <= '0;
      infl_q    <= 1'b0;
      cur_v_q   <= 1'b0;
      nxt_v_q   <= 1'b0;
      cur_q     <= '0;
      nxt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      num_q   <= num_d;
      ptr_q   <= ptr_d;
      infl_q  <= tbl_en;
      cur_v_q <= cur_v_d;
      nxt_v_q <= nxt_v_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      if (acc) begin
        m_valid_q <= 1'b1;
        m_data_q  <= s_data;
        m_bad_q   <= hit;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
        m_bad_q   <= 1'b0;
      end
    end
  end

`ifdef MANUAL_BP_STATS_EN
  logic [ADDR_WIDTH:0] hit_cnt_q;
  assign bp_hit_cnt = hit_cnt_q;
  // saturating count of flagged pixels in the current frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_cnt_q <= '0;
    else if (frame_start) hit_cnt_q <= '0;
    else if (hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_manual_bp_lookup.sv
// tb_manual_bp_lookup: randomized scoreboard bench for manual_bp_lookup on a reduced image size
module tb_manual_bp_lookup;
  localparam int AW = 7, DW = 32, PW = 14, W = 20, H = 12, N = W * H;

  typedef struct { logic [PW-1:0] d; logic b; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, bp_en = 1'b0, frame_start = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [AW:0] bp_num = '0;
  logic [PW-1:0] s_data = '0;
  logic s_ready, m_valid, m_bad, tbl_en;
  logic [PW-1:0] m_data;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_dout;
`ifdef MANUAL_BP_STATS_EN
  logic [AW:0] bp_hit_cnt;
`endif

  manual_bp_lookup #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIX_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .bp_en(bp_en), .bp_num(bp_num), .frame_start(frame_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_bad(m_bad),
    .tbl_en(tbl_en), .tbl_addr(tbl_addr), .tbl_dout(tbl_dout)
`ifdef MANUAL_BP_STATS_EN
    , .bp_hit_cnt(bp_hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (tbl_en) tbl_dout <= mem[tbl_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  exp_t q[$];
  bit flag [0:N-1];
  int idx = 0, num_eff = 0, rd_cnt = 0, bad_seen = 0, rdy_pct = 100, first_acc = -1, last_acc = 0;
  bit in_frame = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference: an entry flags its pixel only if it lies beyond every earlier entry in raster order
  task automatic start_frame(input bit en, input int num);
    int mx, li;
    @(negedge clk);
    s_valid = 1'b0;
    frame_start = 1'b1;
    bp_en = en;
    bp_num = (AW+1)'(num);
    num_eff = en ? (num > (1<<AW) ? (1<<AW) : num) : 0;
    for (int i = 0; i < N; i++) flag[i] = 1'b0;
    mx = -1;
    for (int i = 0; i < num_eff; i++) begin
      li = int'(mem[i][31:16]) * W + int'(mem[i][15:0]);
      if (li > mx) begin
        if (li < N) flag[li] = 1'b1;
        mx = li;
      end
    end
    idx = 0;
    in_frame = 1'b1;
    rd_cnt = 0;
    bad_seen = 0;
    first_acc = -1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic send_pixel(input int vpct);
    bit done = 1'b0;
    exp_t e;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      s_valid = ($urandom_range(99) < vpct);
      s_data = PW'($urandom);
      #4;
      if (s_valid && s_ready) begin
        e.d = s_data;
        e.b = in_frame && flag[idx];
        q.push_back(e);
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (in_frame) begin
          idx++;
          if (idx == N) begin
            idx = 0;
            in_frame = 1'b0;
          end
        end
        done = 1'b1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_ready got 0 for 300 cycles, required 1");
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && q.size() != 0; t++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  task automatic run_frame(input bit en, input int num, input int vpct, input int rdy);
    rdy_pct = rdy;
    start_frame(en, num);
    for (int i = 0; i < N; i++) send_pixel(vpct);
    drain();
  endtask

  task automatic load_019();
    mem[0] = {16'd0, 16'd0};
    mem[1] = {16'd0, 16'd1};
    mem[2] = {16'd5, 16'(W-1)};
    mem[3] = {16'(H-1), 16'(W-1)};
  endtask

  // table read monitor: every read must stay inside the latched entry count
  initial forever begin
    @(negedge clk);
    #4;
    if (tbl_en) begin
      rd_cnt++;
      tests++;
      if (int'(tbl_addr) >= num_eff) begin
        fails++;
        $display("FAIL tbl_addr_range: got %0d required below %0d", tbl_addr, num_eff);
      end
    end
  end

  // output monitor: random backpressure, pop-and-compare on each accepted beat, hold check on stalls
  initial begin
    exp_t e;
    bit hold = 1'b0;
    logic [PW-1:0] held_d;
    logic held_b;
    forever begin
      @(negedge clk);
      m_ready = ($urandom_range(99) < rdy_pct);
      #3;
      if (m_valid) begin
        if (hold) begin
          chk("hold_data", m_data, held_d);
          chk("hold_bad", m_bad, held_b);
        end
        if (m_ready) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got data %0h, required no beat", m_data);
          end else begin
            e = q.pop_front();
            chk("m_data", m_data, e.d);
            chk("m_bad", m_bad, e.b);
            if (m_bad) bad_seen++;
          end
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held_d = m_data;
          held_b = m_bad;
        end
      end else if (hold) begin
        tests++;
        fails++;
        $display("FAIL hold_valid: m_valid got 0 required 1");
        hold = 1'b0;
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_bad", m_bad, 0);
    chk("rst_tbl_en", tbl_en, 0);
    chk("rst_tbl_addr", tbl_addr, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send_pixel(100);
    drain();

    run_frame(1'b1, 0, 90, 80);
    chk("num0_reads", rd_cnt, 0);
    chk("num0_bad", bad_seen, 0);

    load_019();
    run_frame(1'b1, 4, 100, 100);
    chk("t019_bad", bad_seen, 4);
    chk("t019_reads", rd_cnt, 4);
    chk("t019_span", last_acc - first_acc, N - 1);
`ifdef MANUAL_BP_STATS_EN
    chk("t019_hit_cnt", bp_hit_cnt, 4);
`endif

    run_frame(1'b1, 4, 100, 50);
    chk("t019_bp_bad", bad_seen, 4);

    mem[0] = {16'd3, 16'd10};
    mem[1] = {16'd2, 16'd5};
    mem[2] = {16'd3, 16'd12};
    run_frame(1'b1, 3, 100, 100);
    chk("t020_bad", bad_seen, 2);
    chk("t020_reads", rd_cnt, 3);
    chk("t020_span", last_acc - first_acc, N);

    load_019();
    rdy_pct = 70;
    start_frame(1'b1, 4);
    for (int i = 0; i < 6 * W + 2; i++) send_pixel(85);
    start_frame(1'b0, 4);
    for (int i = 0; i < N; i++) send_pixel(85);
    drain();
    chk("abort_bad", bad_seen, 0);
    chk("abort_reads", rd_cnt, 0);

    for (int f = 0; f < 6; f++) begin
      n = 0;
      for (int li = 0; li < N && n < (1<<AW); li++)
        if ($urandom_range(99) < 30) begin
          mem[n] = {16'(li / W), 16'(li % W)};
          n++;
        end
      while (n < (1<<AW)) begin
        mem[n] = {16'($urandom_range(H-1)), 16'($urandom_range(W-1))};
        n++;
      end
      if ($urandom_range(1) == 1) begin
        mem[2] = mem[9];
        mem[5] = mem[4];
      end
      run_frame($urandom_range(9) != 0, $urandom_range(255), 60 + $urandom_range(40), 30 + $urandom_range(70));
    end

    for (int i = 0; i < 8; i++) send_pixel(100);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
